// File: rtl/recip_fp_arbiter.sv
// ---------------------------------------------------------------------------
// recip_fp_arbiter
//   Shares one combinational floating-point reciprocal core between NREQ
//   requesters. A round-robin arbiter picks one operand per cycle and feeds a
//   two-stage valid/ready pipeline: S1 holds the operand, S2 holds the result.
//   Each result is tagged with the ID of the requester that issued it. Sticky
//   exception flags are accumulated for a status register.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester operand valid            [NREQ]
//   req_ready  per-requester accept, one-hot or zero  [NREQ]
//   req_data   operands, requester i at [i*TYPE +: TYPE]
//   rsp_valid  result valid
//   rsp_ready  downstream accept
//   rsp_data   reciprocal result                      [TYPE]
//   rsp_id     requester that issued the operand      [IDW]
//   rsp_flags  exception flags {NV,DZ,OF,UF,NX}       [5]
//   flags_acc  sticky OR of rsp_flags over handshakes [5]
//   flags_clr  synchronous clear of flags_acc
//
// Also contains recip_fp_core, the purely combinational reciprocal unit.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// recip_fp_core
//   Combinational IEEE-754 reciprocal (binary16 or binary32), round to
//   nearest even. Subnormal inputs are normalised; tiny results are
//   denormalised before rounding. Flags: [4]NV [3]DZ [2]OF [1]UF [0]NX.
//   a_i      operand
//   y_o      1/a_i
//   flags_o  exception flags for this operation
// ---------------------------------------------------------------------------
module recip_fp_core #(
  parameter int TYPE = 32
) (
  input  logic [TYPE-1:0] a_i,
  output logic [TYPE-1:0] y_o,
  output logic [4:0]      flags_o
);
  localparam int EW   = (TYPE == 16) ? 5 : 8;
  localparam int MW   = TYPE - 1 - EW;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int ES   = EW + 3;          // signed exponent arithmetic width
  localparam int DW   = 2 * MW + 3;      // dividend width
  localparam int LW   = $clog2(MW + 1);
  localparam int F_NV = 4;
  localparam int F_DZ = 3;
  localparam int F_OF = 2;
  localparam int F_UF = 1;
  localparam int F_NX = 0;
  // 2^(2*MW+2): dividing by a normalised significand leaves MW+2 quotient
  // bits, i.e. hidden bit, MW fraction bits and one guard bit.
  localparam logic [DW-1:0]   NUM  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [TYPE-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  logic            sign;
  logic [EW-1:0]   exp_in;
  logic [MW-1:0]   frac_in;
  logic            is_nan, is_inf, is_zero;
  logic [MW:0]     sig, sig_n, sig_r;
  logic [LW-1:0]   msb, lz;
  logic [DW-1:0]   div_den, q_full, r_full;
  logic            exact_one;
  logic [ES-1:0]   e_in, r_exp, biased, sh;
  logic            tiny, ovf, grd, stk, round_up, inexact;
  logic [EW-1:0]   exp_field;
  logic [TYPE-2:0] mag_r;

  always_comb begin
    sign    = a_i[TYPE-1];
    exp_in  = a_i[TYPE-2:MW];
    frac_in = a_i[MW-1:0];
    is_nan  = (&exp_in) & (|frac_in);
    is_inf  = (&exp_in) & ~(|frac_in);
    is_zero = ~(|exp_in) & ~(|frac_in);

    // Normalise the significand so subnormals go through the same divider.
    sig = {|exp_in, frac_in};
    msb = '0;
    for (int i = 0; i <= MW; i++) begin
      if (sig[i]) msb = LW'(i);
    end
    lz    = LW'(MW) - msb;
    sig_n = sig << lz;
    e_in  = ((exp_in == '0) ? ES'(1) : ES'(exp_in)) - ES'(BIAS) - ES'(lz);

    div_den = is_zero ? DW'(1) : DW'(sig_n);
    q_full  = NUM / div_den;
    r_full  = NUM % div_den;

    // Quotient reaches 2^(MW+2) only for a significand of exactly 1.0.
    exact_one = q_full[MW+2];
    if (exact_one) begin
      sig_r = {1'b1, {MW{1'b0}}};
      grd   = 1'b0;
      stk   = 1'b0;
      r_exp = ES'(0) - e_in;
    end else begin
      sig_r = q_full[MW+1:1];
      grd   = q_full[0];
      // Quotient bits above MW+2 are always zero; folding them in is harmless.
      stk   = (|r_full) | (|q_full[DW-1:MW+3]);
      r_exp = ES'(0) - e_in - ES'(1);
    end

    biased = r_exp + ES'(BIAS);
    tiny   = biased[ES-1] | (biased == '0);
    ovf    = ~biased[ES-1] & (biased >= ES'((1 << EW) - 1));

    // Tiny results: shift into subnormal position, collecting lost bits.
    sh = tiny ? (ES'(1) - biased) : '0;
    for (int k = 0; k < MW + 2; k++) begin
      if (ES'(k) < sh) begin
        stk   = stk | grd;
        grd   = sig_r[0];
        sig_r = sig_r >> 1;
      end
    end

    // Adding the round bit to {exp,frac} lets a fraction carry bump the
    // exponent (and a subnormal become the smallest normal) for free.
    exp_field = tiny ? '0 : biased[EW-1:0];
    round_up  = grd & (stk | sig_r[0]);
    mag_r     = {exp_field, sig_r[MW-1:0]} + (TYPE-1)'(round_up);
    inexact   = grd | stk;
    if (&mag_r[TYPE-2:MW]) ovf = 1'b1;

    y_o           = {sign, mag_r};
    flags_o       = '0;
    flags_o[F_NX] = inexact;
    flags_o[F_UF] = tiny & inexact;   // tininess detected before rounding

    if (ovf) begin
      y_o           = {sign, {EW{1'b1}}, {MW{1'b0}}};
      flags_o       = '0;
      flags_o[F_OF] = 1'b1;
      flags_o[F_NX] = 1'b1;
    end

    if (is_nan) begin
      y_o           = QNAN;
      flags_o       = '0;
      flags_o[F_NV] = 1'b1;
    end else if (is_inf) begin
      y_o     = {sign, {(TYPE-1){1'b0}}};
      flags_o = '0;
    end else if (is_zero) begin
      y_o           = {sign, {EW{1'b1}}, {MW{1'b0}}};
      flags_o       = '0;
      flags_o[F_DZ] = 1'b1;
    end
  end
endmodule

module recip_fp_arbiter #(
  parameter int TYPE = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*TYPE-1:0] req_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [TYPE-1:0]      rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic [4:0]           rsp_flags,
  output logic [4:0]           flags_acc,
  input  logic                 flags_clr
);
  logic [TYPE-1:0] req_word [NREQ];

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            s1_v_q, s2_v_q;
  logic [TYPE-1:0] s1_data_q, s2_data_q;
  logic [IDW-1:0]  s1_id_q, s2_id_q;
  logic [4:0]      s2_flags_q;
  logic [4:0]      flags_acc_q, flags_acc_d;

  logic            adv1, adv2;
  logic            found, take;
  logic [IDW-1:0]  gid, cand;
  logic [NREQ-1:0] grant;
  logic [TYPE-1:0] sel_data;
  logic [TYPE-1:0] core_y;
  logic [4:0]      core_flags;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_word[gi] = req_data[gi*TYPE +: TYPE];
    end
  endgenerate

  assign adv2 = ~s2_v_q | rsp_ready;
  assign adv1 = ~s1_v_q | adv2;

  // Round-robin search from ptr. Only valids and pipeline state steer the
  // grant, so req_ready never depends on req_data.
  always_comb begin
    found = 1'b0;
    gid   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gid   = cand;
      end
    end
    // No grants while reset is held: S1 could not capture the operand.
    take  = found & adv1 & rst_n;
    grant = '0;
    if (take) grant[gid] = 1'b1;
    sel_data = req_word[gid];
    ptr_d = ptr_q;
    if (take) ptr_d = (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
  end

  assign req_ready = grant;

  recip_fp_core #(.TYPE(TYPE)) u_core (
    .a_i     (s1_data_q),
    .y_o     (core_y),
    .flags_o (core_flags)
  );

  // A handshake in the same cycle as a clear still lands in the accumulator.
  always_comb begin
    flags_acc_d = flags_clr ? 5'd0 : flags_acc_q;
    if (s2_v_q && rsp_ready) flags_acc_d = flags_acc_d | s2_flags_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      s2_v_q      <= 1'b0;
      s2_data_q   <= '0;
      s2_id_q     <= '0;
      s2_flags_q  <= '0;
      flags_acc_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      flags_acc_q <= flags_acc_d;
      if (adv1) begin
        s1_v_q    <= take;
        s1_data_q <= sel_data;
        s1_id_q   <= gid;
      end
      if (adv2) begin
        s2_v_q     <= s1_v_q;
        s2_data_q  <= core_y;
        s2_id_q    <= s1_id_q;
        s2_flags_q <= core_flags;
      end
    end
  end

  assign rsp_valid = s2_v_q;
  assign rsp_data  = s2_data_q;
  assign rsp_id    = s2_id_q;
  assign rsp_flags = s2_flags_q;
  assign flags_acc = flags_acc_q;
endmodule

// File: tb/tb_recip_fp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_recip_fp_arbiter
//   Directed bench for recip_fp_arbiter (TYPE=32, NREQ=4). Expected results
//   come from a hand-computed operand/result table; a monitor records every
//   response handshake and each scenario compares it against its expectations.
// ---------------------------------------------------------------------------
module tb_recip_fp_arbiter;
  localparam int TYPE = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*TYPE-1:0] req_data;
  logic                 rsp_valid, rsp_ready;
  logic [TYPE-1:0]      rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic [4:0]           rsp_flags, flags_acc;
  logic                 flags_clr;

  recip_fp_arbiter #(.TYPE(TYPE), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_flags (rsp_flags),
    .flags_acc (flags_acc),
    .flags_clr (flags_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0]  id;
    logic [TYPE-1:0] data;
    logic [4:0]      flags;
    int              stamp;
  } rsp_t;

  rsp_t got_q[$];
  rsp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;

  logic [31:0] vec  [4];
  logic [31:0] t7v  [6];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so values seen here are the
  // ones present at the next handshake edge.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      rsp_t r;
      r.id    = rsp_id;
      r.data  = rsp_data;
      r.flags = rsp_flags;
      r.stamp = cyc;
      got_q.push_back(r);
      $display("rsp cyc=%0d id=%0d data=%h flags=%b", cyc, rsp_id, rsp_data, rsp_flags);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // {flags, result} for every operand used here, worked out by hand.
  function automatic logic [36:0] ref_recip(input logic [31:0] x);
    case (x)
      32'h40000000: ref_recip = {5'b00000, 32'h3F000000}; // 2.0 -> 0.5
      32'h40800000: ref_recip = {5'b00000, 32'h3E800000}; // 4.0 -> 0.25
      32'h40400000: ref_recip = {5'b00001, 32'h3EAAAAAB}; // 3.0 -> 1/3, NX
      32'h3F000000: ref_recip = {5'b00000, 32'h40000000}; // 0.5 -> 2.0
      32'h80000000: ref_recip = {5'b01000, 32'hFF800000}; // -0 -> -Inf, DZ
      32'h00000000: ref_recip = {5'b01000, 32'h7F800000}; // +0 -> +Inf, DZ
      32'h7F800000: ref_recip = {5'b00000, 32'h00000000}; // Inf -> 0
      32'h7FC00000: ref_recip = {5'b10000, 32'h7FC00000}; // NaN -> qNaN, NV
      32'h00000001: ref_recip = {5'b00101, 32'h7F800000}; // min subnormal -> Inf, OF|NX
      32'h7F7FFFFF: ref_recip = {5'b00011, 32'h00200000}; // max finite -> subnormal, UF|NX
      32'h00800000: ref_recip = {5'b00000, 32'h7E800000}; // 2^-126 -> 2^126
      32'hC0000000: ref_recip = {5'b00000, 32'hBF000000}; // -2.0 -> -0.5
      32'h7F000000: ref_recip = {5'b00000, 32'h00400000}; // 2^127 -> 2^-127 exact
      default:      ref_recip = '0;
    endcase
  endfunction

  task automatic push_exp(input int id, input logic [31:0] x);
    rsp_t        e;
    logic [36:0] r;
    r       = ref_recip(x);
    e.id    = IDW'(id);
    e.data  = r[31:0];
    e.flags = r[36:32];
    e.stamp = 0;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [31:0] d);
    req_data[i*TYPE +: TYPE] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_rsps(input string tag, input bit consec);
    int n;
    chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_id%0d", tag, i),    32'(got_q[i].id),    32'(exp_q[i].id));
      chk($sformatf("%s_data%0d", tag, i),  got_q[i].data,       exp_q[i].data);
      chk($sformatf("%s_flags%0d", tag, i), 32'(got_q[i].flags), 32'(exp_q[i].flags));
      if (consec && i > 0)
        chk($sformatf("%s_gap%0d", tag, i), 32'(got_q[i].stamp - got_q[i-1].stamp), 32'd1);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec[0] = 32'h40000000; vec[1] = 32'h40800000;
    vec[2] = 32'h40400000; vec[3] = 32'h3F000000;
    t7v[0] = 32'h00000001; t7v[1] = 32'h7F7FFFFF; t7v[2] = 32'h00800000;
    t7v[3] = 32'hC0000000; t7v[4] = 32'h00000000; t7v[5] = 32'h7F000000;

    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    rsp_ready = 1'b0;
    flags_clr = 1'b0;

    // Reset state, with every requester asking.
    #3;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_data",  rsp_data,       32'h0);
    chk("rst_acc",   32'(flags_acc), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();

    // 1: single op, 2-cycle latency.
    set_req(0, 32'h40000000);
    req_valid = 4'b0001;
    push_exp(0, 32'h40000000);
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("t1_s1only", 32'(rsp_valid), 32'h0);
    tick();
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_data",  rsp_data,       32'h3F000000);
    chk("t1_id",    32'(rsp_id),    32'h0);
    chk("t1_flags", 32'(rsp_flags), 32'h0);
    tick();
    chk("t1_empty", 32'(rsp_valid), 32'h0);
    compare_rsps("t1", 1'b0);

    // 2: -0 on requester 2, DZ sticky until cleared.
    set_req(2, 32'h80000000);
    req_valid = 4'b0100;
    push_exp(2, 32'h80000000);
    #1 chk("t2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    chk("t2_data",  rsp_data,       32'hFF800000);
    chk("t2_flags", 32'(rsp_flags), 32'h08);
    tick();
    chk("t2_acc", 32'(flags_acc), 32'h08);
    repeat (3) tick();
    chk("t2_sticky", 32'(flags_acc), 32'h08);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    chk("t2_clr", 32'(flags_acc), 32'h0);
    compare_rsps("t2", 1'b0);

    // Infinity on requester 3 (also moves the pointer back to 0).
    set_req(3, 32'h7F800000);
    req_valid = 4'b1000;
    push_exp(3, 32'h7F800000);
    #1 chk("t2b_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    repeat (3) tick();
    compare_rsps("t2b", 1'b0);

    // 3: all four valid, rotating grants and back-to-back results.
    for (int i = 0; i < 4; i++) set_req(i, vec[i]);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("t3_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      push_exp(k % 4, vec[k % 4]);
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    compare_rsps("t3", 1'b1);

    // 4: back-pressure with everyone asking.
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1 chk("t4_grant_a", 32'(req_ready), 32'h4);
    push_exp(2, vec[2]);
    tick();
    #1 chk("t4_grant_b", 32'(req_ready), 32'h8);
    push_exp(3, vec[3]);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t4_blocked%0d", k), 32'(req_ready), 32'h0);
      chk($sformatf("t4_hold_v%0d", k),  32'(rsp_valid), 32'h1);
      chk($sformatf("t4_hold_id%0d", k), 32'(rsp_id),    32'h2);
      chk($sformatf("t4_hold_d%0d", k),  rsp_data,       32'h3EAAAAAB);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("t4_release_grant", 32'(req_ready), 32'h1);
    push_exp(0, vec[0]);
    tick();
    req_valid = '0;
    repeat (4) tick();
    compare_rsps("t4", 1'b1);
    chk("t4_acc", 32'(flags_acc), 32'h01);

    // 5: clear in the same cycle as a NaN handshake.
    set_req(1, 32'h7FC00000);
    req_valid = 4'b0010;
    push_exp(1, 32'h7FC00000);
    #1 chk("t5_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    chk("t5_data",  rsp_data,       32'h7FC00000);
    chk("t5_flags", 32'(rsp_flags), 32'h10);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    chk("t5_acc", 32'(flags_acc), 32'h10);
    tick();
    compare_rsps("t5", 1'b0);

    // 6: reset while both stages hold work.
    rsp_ready = 1'b0;
    set_req(0, 32'h40800000);
    set_req(1, 32'h40000000);
    req_valid = 4'b0011;
    #1 chk("t6_grant_a", 32'(req_ready), 32'h1);
    tick();
    #1 chk("t6_grant_b", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    chk("t6_full", 32'(rsp_valid), 32'h1);
    req_valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rsp_valid), 32'h0);
    chk("t6_rst_data",  rsp_data,       32'h0);
    chk("t6_rst_id",    32'(rsp_id),    32'h0);
    chk("t6_rst_flags", 32'(rsp_flags), 32'h0);
    chk("t6_rst_acc",   32'(flags_acc), 32'h0);
    chk("t6_rst_ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();
    compare_rsps("t6_stale", 1'b0);
    req_valid = 4'b1111;
    #1 chk("t6_ptr0", 32'(req_ready), 32'h1);
    push_exp(0, 32'h40800000);
    tick();
    req_valid = '0;
    repeat (3) tick();
    compare_rsps("t6", 1'b0);

    // 7: range corners streamed from one requester at full rate.
    req_valid = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      set_req(0, t7v[k]);
      #1 chk($sformatf("t7_ready%0d", k), 32'(req_ready), 32'h1);
      push_exp(0, t7v[k]);
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    compare_rsps("t7", 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
